// File: rtl/cordic_engine.sv
// Iterative handshaked CORDIC engine: circular, linear and hyperbolic modes.
// Build option CORDIC_HYPERBOLIC_EN enables hyperbolic mode (atanh LUT, repeats).

module cordic_engine #(
    parameter int p_WIDTH      = 16,
    parameter int p_ITERATIONS = 14,
    parameter int p_ANGLE_FRAC = p_WIDTH - 3
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               inValid,
    output logic               inReady,
    input  logic [1:0]         inMode,
    input  logic               inVectoring,
    input  logic [p_WIDTH-1:0] inX,
    input  logic [p_WIDTH-1:0] inY,
    input  logic [p_WIDTH-1:0] inZ,
    output logic               outValid,
    input  logic               outReady,
    output logic [p_WIDTH-1:0] outX,
    output logic [p_WIDTH-1:0] outY,
    output logic [p_WIDTH-1:0] outZ,
    output logic [2:0]         outOverflow,
    output logic               outError,
    output logic               busy
);

    localparam int c_IW     = $clog2(p_ITERATIONS + 2);
    localparam int c_SW     = $clog2(p_ITERATIONS + 3);
    localparam int c_LUT    = 1 << c_IW;
    localparam int c_G      = 56;
    localparam int c_HSTEPS = p_ITERATIONS + ((p_ITERATIONS >= 4) ? 1 : 0)
                            + ((p_ITERATIONS >= 13) ? 1 : 0);

    // kind 0: atan, 1: atanh, 2: 2^-i; series evaluated with 56 fraction bits
    function automatic logic [p_WIDTH-1:0] lut_val(input int kind, input int idx);
        longint v;
        longint t;
        longint p;
        int     e;
        v = 0;
        if (kind == 2) begin
            v = 64'sd1 <<< (c_G - idx);
        end else if (kind == 0 && idx == 0) begin
            v = 64'sd3373259426 <<< (c_G - 32);
        end else if (idx > 0) begin
            for (int k = 0; k < 32; k++) begin
                e = c_G - idx * (2 * k + 1);
                if (e >= 0) begin
                    t = (64'sd1 <<< e) / longint'(2 * k + 1);
                    if (kind == 0 && k[0]) v = v - t;
                    else v = v + t;
                end
            end
        end
        p = (v + (64'sd1 <<< (c_G - p_ANGLE_FRAC - 1))) >>> (c_G - p_ANGLE_FRAC);
        return p_WIDTH'(p);
    endfunction

    logic [p_WIDTH-1:0] w_atan [c_LUT];
    logic [p_WIDTH-1:0] w_lin  [c_LUT];

    for (genvar g = 0; g < c_LUT; g++) begin : g_lut
        localparam logic [p_WIDTH-1:0] c_A = (g <= p_ITERATIONS) ? lut_val(0, g) : '0;
        localparam logic [p_WIDTH-1:0] c_L = (g <= p_ITERATIONS) ? lut_val(2, g) : '0;
        assign w_atan[g] = c_A;
        assign w_lin[g]  = c_L;
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    r_state, w_next;
    logic signed [p_WIDTH-1:0] r_x, r_y, r_z;
    logic [1:0]                r_mode;
    logic                      r_vec;
    logic [2:0]                r_ovf;
    logic                      r_err;
    logic [c_SW-1:0]           r_step;
    logic [c_IW-1:0]           r_i;

    logic                      w_legal, w_d, w_last, w_hold;
    logic [c_SW-1:0]           w_lastStep;
    logic signed [p_WIDTH-1:0] w_xs, w_ys, w_dx, w_dy, w_dz, w_nx, w_ny, w_nz;
    logic                      w_ovx, w_ovy, w_ovz;

`ifdef CORDIC_HYPERBOLIC_EN
    logic [p_WIDTH-1:0] w_atanh [c_LUT];
    logic               r_rep;

    for (genvar g = 0; g < c_LUT; g++) begin : g_hlut
        localparam logic [p_WIDTH-1:0] c_H =
            (g >= 1 && g <= p_ITERATIONS) ? lut_val(1, g) : '0;
        assign w_atanh[g] = c_H;
    end

    assign w_legal = (inMode != 2'b11);
    // indices 4 and 13 run twice; r_rep marks the second pass
    assign w_hold  = (r_mode == 2'b01) && !r_rep &&
                     ((p_ITERATIONS >= 4 && r_i == c_IW'(4)) ||
                      (p_ITERATIONS >= 13 && r_i == c_IW'(13)));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_rep <= 1'b0;
        else if (r_state == S_RUN) r_rep <= w_hold;
        else r_rep <= 1'b0;
    end
`else
    assign w_legal = (inMode == 2'b00) || (inMode == 2'b10);
    assign w_hold  = 1'b0;
`endif

    assign w_xs       = r_x >>> r_i;
    assign w_ys       = r_y >>> r_i;
    assign w_d        = r_vec ? r_y[p_WIDTH-1] : ~r_z[p_WIDTH-1];
    assign w_lastStep = (r_mode == 2'b01) ? c_SW'(c_HSTEPS - 1)
                                          : c_SW'(p_ITERATIONS - 1);
    assign w_last     = (r_step == w_lastStep);

    always_comb begin
        w_dx = '0;
        w_dy = '0;
        w_dz = '0;
        case (r_mode)
            2'b00: begin
                w_dx = w_d ? -w_ys : w_ys;
                w_dy = w_d ? w_xs : -w_xs;
                w_dz = w_d ? -w_atan[r_i] : w_atan[r_i];
            end
            2'b10: begin
                w_dy = w_d ? w_xs : -w_xs;
                w_dz = w_d ? -w_lin[r_i] : w_lin[r_i];
            end
`ifdef CORDIC_HYPERBOLIC_EN
            2'b01: begin
                w_dx = w_d ? w_ys : -w_ys;
                w_dy = w_d ? w_xs : -w_xs;
                w_dz = w_d ? -w_atanh[r_i] : w_atanh[r_i];
            end
`endif
            default: ;
        endcase
    end

    assign w_nx  = r_x + w_dx;
    assign w_ny  = r_y + w_dy;
    assign w_nz  = r_z + w_dz;
    assign w_ovx = (r_x[p_WIDTH-1] == w_dx[p_WIDTH-1]) && (w_nx[p_WIDTH-1] != r_x[p_WIDTH-1]);
    assign w_ovy = (r_y[p_WIDTH-1] == w_dy[p_WIDTH-1]) && (w_ny[p_WIDTH-1] != r_y[p_WIDTH-1]);
    assign w_ovz = (r_z[p_WIDTH-1] == w_dz[p_WIDTH-1]) && (w_nz[p_WIDTH-1] != r_z[p_WIDTH-1]);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (inValid) w_next = w_legal ? S_RUN : S_DONE;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (outReady) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_mode <= '0;
            r_vec  <= 1'b0;
            r_ovf  <= '0;
            r_err  <= 1'b0;
            r_step <= '0;
            r_i    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (inValid) begin
                    r_x    <= inX;
                    r_y    <= inY;
                    r_z    <= inZ;
                    r_mode <= inMode;
                    r_vec  <= inVectoring;
                    r_ovf  <= '0;
                    r_err  <= ~w_legal;
                    r_step <= '0;
                    r_i    <= (inMode == 2'b01) ? c_IW'(1) : '0;
                end
                S_RUN: begin
                    r_x    <= w_nx;
                    r_y    <= w_ny;
                    r_z    <= w_nz;
                    r_ovf  <= r_ovf | {w_ovz, w_ovy, w_ovx};
                    r_step <= r_step + 1'b1;
                    if (!w_hold) r_i <= r_i + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign inReady     = rstN && (r_state == S_IDLE);
    assign outValid    = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign outX        = r_x;
    assign outY        = r_y;
    assign outZ        = r_z;
    assign outOverflow = r_ovf;
    assign outError    = r_err;

endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine with a real-math reference model.
// Expectations follow CORDIC_HYPERBOLIC_EN when it is defined for the build.

module tb_cordic_engine;

    localparam int W = 16;
    localparam int N = 14;
`ifdef CORDIC_HYPERBOLIC_EN
    localparam bit HYP = 1'b1;
`else
    localparam bit HYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [1:0]   inMode = 2'b00;
    logic         inVectoring = 1'b0;
    logic [W-1:0] inX = '0;
    logic [W-1:0] inY = '0;
    logic [W-1:0] inZ = '0;
    logic         outValid;
    logic         outReady = 1'b0;
    logic [W-1:0] outX, outY, outZ;
    logic [2:0]   outOverflow;
    logic         outError;
    logic         busy;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc = 0;
    int   op_id = 0;
    int   seen_id = 0;
    bit   pending = 1'b0;
    int   e_x, e_y, e_z, e_lat;
    logic [2:0] e_ovf;
    logic e_err;

    cordic_engine dut (
        .clk(clk), .rstN(rstN),
        .inValid(inValid), .inReady(inReady),
        .inMode(inMode), .inVectoring(inVectoring),
        .inX(inX), .inY(inY), .inZ(inZ),
        .outValid(outValid), .outReady(outReady),
        .outX(outX), .outY(outY), .outZ(outZ),
        .outOverflow(outOverflow), .outError(outError), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic near(input string name, input int act, input int tgt, input int tol);
        n_checks++;
        if (act < tgt - tol || act > tgt + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, tgt, tol);
        end
    endtask

    function automatic int w16(input int v);
        logic signed [15:0] s;
        s = v[15:0];
        return int'(s);
    endfunction

    function automatic int add_ov(input int a, input int b, output bit ov);
        int s;
        s  = w16(a + b);
        ov = ((a < 0) == (w16(b) < 0)) && ((s < 0) != (a < 0));
        return s;
    endfunction

    function automatic int atan_c(input int i);
        return $rtoi($atan(1.0 / real'(1 << i)) * 8192.0 + 0.5);
    endfunction

    function automatic int atanh_c(input int i);
        return $rtoi($atanh(1.0 / real'(1 << i)) * 8192.0 + 0.5);
    endfunction

    function automatic int lin_c(input int i);
        return $rtoi(8192.0 / real'(1 << i) + 0.5);
    endfunction

    task automatic model(input logic [1:0] m, input bit v, input int x0, y0, z0);
        int q[$];
        int x, y, z, ax, ay, az, sg, i;
        bit ox, oy, oz, legal;
        legal = (m == 2'b00) || (m == 2'b10) || (HYP && m == 2'b01);
        x = w16(x0);
        y = w16(y0);
        z = w16(z0);
        e_ovf = 3'b000;
        e_err = !legal;
        e_lat = 1;
        if (legal) begin
            if (m == 2'b01) begin
                for (int k = 1; k <= N; k++) begin
                    q.push_back(k);
                    if (k == 4 || k == 13) q.push_back(k);
                end
            end else begin
                for (int k = 0; k < N; k++) q.push_back(k);
            end
            foreach (q[s]) begin
                i  = q[s];
                sg = (v ? (y < 0) : (z >= 0)) ? 1 : -1;
                if (m == 2'b00) begin
                    ax = -sg * (y >>> i);
                    ay = sg * (x >>> i);
                    az = -sg * atan_c(i);
                end else if (m == 2'b01) begin
                    ax = sg * (y >>> i);
                    ay = sg * (x >>> i);
                    az = -sg * atanh_c(i);
                end else begin
                    ax = 0;
                    ay = sg * (x >>> i);
                    az = -sg * lin_c(i);
                end
                x = add_ov(x, ax, ox);
                y = add_ov(y, ay, oy);
                z = add_ov(z, az, oz);
                e_ovf = e_ovf | {oz, oy, ox};
            end
            e_lat = q.size() + 1;
        end
        e_x = x;
        e_y = y;
        e_z = z;
    endtask

    // checks every cycle a result is presented; latency counted as the edge that first sees outValid
    initial forever begin
        @(negedge clk);
        if (rstN && pending && outValid) begin
            if (seen_id != op_id) begin
                seen_id = op_id;
                chk("latency", cyc + 1 - acc, e_lat);
            end
            chk("outX", int'($signed(outX)), e_x);
            chk("outY", int'($signed(outY)), e_y);
            chk("outZ", int'($signed(outZ)), e_z);
            chk("outOverflow", int'(outOverflow), int'(e_ovf));
            chk("outError", int'(outError), int'(e_err));
            chk("inReady_in_done", int'(inReady), 0);
            chk("busy_in_done", int'(busy), 1);
        end
    end

    task automatic run_op(input logic [1:0] m, input bit v, input int x, y, z,
                          input int hold, input bit glitch,
                          output int ox, oy, oz, output logic [2:0] oo, output logic oe);
        int t;
        ox = 0; oy = 0; oz = 0; oo = '0; oe = 1'b0;
        @(negedge clk);
        t = 0;
        while (!inReady && t < 50) begin @(negedge clk); t++; end
        chk("accept_ready", int'(inReady), 1);
        model(m, v, x, y, z);
        inMode = m; inVectoring = v;
        inX = x[15:0]; inY = y[15:0]; inZ = z[15:0];
        inValid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        op_id++;
        pending = 1'b1;
        inValid = 1'b0;
        inX = 16'h7fff; inY = 16'h8001; inZ = 16'h1234;
        inMode = 2'b11; inVectoring = !v;
        if (glitch) begin
            repeat (3) begin @(negedge clk); inValid = 1'b1; end
            @(negedge clk);
            inValid = 1'b0;
        end
        t = 0;
        while (!outValid && t < 100) begin @(negedge clk); t++; end
        chk("done_seen", int'(outValid), 1);
        ox = int'($signed(outX));
        oy = int'($signed(outY));
        oz = int'($signed(outZ));
        oo = outOverflow;
        oe = outError;
        repeat (hold) @(negedge clk);
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        pending = 1'b0;
        outReady = 1'b0;
        chk("released", int'(outValid), 0);
        chk("ready_again", int'(inReady), 1);
    endtask

    initial begin
        int ox, oy, oz;
        logic [2:0] oo;
        logic oe;

        repeat (3) @(negedge clk);
        chk("rst_inReady", int'(inReady), 0);
        chk("rst_outValid", int'(outValid), 0);
        chk("rst_outX", int'(outX), 0);
        chk("rst_outY", int'(outY), 0);
        chk("rst_outZ", int'(outZ), 0);
        chk("rst_ovf", int'(outOverflow), 0);
        chk("rst_err", int'(outError), 0);
        chk("rst_busy", int'(busy), 0);
        rstN = 1'b1;
        @(negedge clk);
        chk("idle_inReady", int'(inReady), 1);

        run_op(2'b00, 1'b0, 4975, 0, 6434, 0, 1'b0, ox, oy, oz, oo, oe);
        near("circ_rot_x", ox, 5793, 4);
        near("circ_rot_y", oy, 5793, 4);
        near("circ_rot_z", oz, 0, 4);

        run_op(2'b00, 1'b1, 8192, 8192, 0, 0, 1'b0, ox, oy, oz, oo, oe);
        near("circ_vec_z", oz, 6434, 4);
        near("circ_vec_x", ox, 19078, 8);
        near("circ_vec_y", oy, 0, 4);
        chk("circ_vec_ovf", int'(oo), 0);

        run_op(2'b10, 1'b0, 8192, 0, 4096, 0, 1'b0, ox, oy, oz, oo, oe);
        near("lin_rot_y", oy, 4096, 2);

        run_op(2'b10, 1'b1, 8192, 2048, 0, 0, 1'b0, ox, oy, oz, oo, oe);
        near("lin_vec_z", oz, 2048, 2);

        run_op(2'b01, 1'b0, 9892, 0, 4096, 0, 1'b0, ox, oy, oz, oo, oe);
`ifdef CORDIC_HYPERBOLIC_EN
        near("hyp_x", ox, 9238, 6);
        near("hyp_y", oy, 4269, 6);
        chk("hyp_err", int'(oe), 0);
`else
        chk("hyp_off_err", int'(oe), 1);
        chk("hyp_off_x", ox, 9892);
        chk("hyp_off_y", oy, 0);
        chk("hyp_off_z", oz, 4096);
`endif

        run_op(2'b00, 1'b1, 30000, 30000, 0, 3, 1'b0, ox, oy, oz, oo, oe);
        chk("ovf_x_sticky", int'(oo[0]), 1);

        run_op(2'b11, 1'b0, 123, -456, 789, 0, 1'b0, ox, oy, oz, oo, oe);
        chk("mode11_err", int'(oe), 1);
        chk("mode11_y", oy, -456);

        run_op(2'b00, 1'b0, 6000, 1000, -5000, 10, 1'b1, ox, oy, oz, oo, oe);
        repeat (3) begin
            @(negedge clk);
            chk("no_queued_op", int'(busy), 0);
        end

        @(negedge clk);
        inMode = 2'b00; inVectoring = 1'b0;
        inX = 16'd4975; inY = 16'd0; inZ = 16'd6434;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_mid_run", int'(busy), 1);
        rstN = 1'b0;
        #1;
        chk("mrst_outX", int'(outX), 0);
        chk("mrst_outY", int'(outY), 0);
        chk("mrst_outZ", int'(outZ), 0);
        chk("mrst_valid", int'(outValid), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_ovf", int'(outOverflow), 0);
        chk("mrst_inReady", int'(inReady), 0);
        @(negedge clk);
        rstN = 1'b1;

        run_op(2'b00, 1'b0, 3000, -2000, -3000, 0, 1'b0, ox, oy, oz, oo, oe);
        run_op(2'b00, 1'b1, -5000, 3000, 100, 0, 1'b0, ox, oy, oz, oo, oe);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_engine.md
# cordic_engine

Iterative, handshaked CORDIC engine that performs all micro-rotations of one operation internally, one per clock. It supports circular, linear and hyperbolic coordinate systems in both rotation and vectoring modes, and includes an angle LUT, hyperbolic repeat iterations and sticky overflow reporting. It sits behind the accelerator's register front-end and replaces per-step external sequencing of the single-step datapath.

## Interface

- p_WIDTH, 16: datapath width of x, y and z (signed two's complement); legal range 8..32.
- p_ITERATIONS, 14: number of shift indices N; legal range 1..p_WIDTH-2.
- p_ANGLE_FRAC, p_WIDTH-3: fractional bits of z and of LUT constants.
- clk  in  1  clock; all state updates on the rising edge.
- rstN  in  1  asynchronous, active-low reset.
- inValid  in  1  operation request.
- inReady  out  1  engine can accept an operation.
- inMode  in  2  00 = circular, 01 = hyperbolic, 10 = linear, 11 = reserved.
- inVectoring  in  1  1 = vectoring (drive y to 0), 0 = rotation (drive z to 0).
- inX, inY, inZ  in  p_WIDTH  initial operands.
- outValid  out  1  result available.
- outReady  in  1  consumer accepts the result.
- outX, outY, outZ  out  p_WIDTH  final operands.
- outOverflow  out  3  sticky {z, y, x} overflow bits for this operation.
- outError  out  1  unsupported mode requested.
- busy  out  1  state is not IDLE.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: inReady=1. On inValid: latch the operands, mode and vectoring bit; clear overflow; set step=0 and the shift index i to its start value (0 for circular/linear, 1 for hyperbolic). If the mode is illegal, go to DONE with outError=1 and the operands passed through unchanged. Otherwise go to RUN.
- RUN: one micro-step per cycle.
  - Direction d: rotation mode, d=1 when z≥0; vectoring mode, d=1 when y<0.
  - Circular: d=1 gives x-=y>>>i, y+=x>>>i, z-=atan(2^-i); d=0 gives the opposite signs.
  - Hyperbolic: d=1 gives x+=y>>>i, y+=x>>>i, z-=atanh(2^-i); d=0 negates all three deltas.
  - Linear: x unchanged; d=1 gives y+=x>>>i, z-=2^-i; d=0 negates both deltas.
  - All shifts are arithmetic. All sums are wrapped p_WIDTH-bit values; there is no saturation.
  - Per-component overflow: both addends have the same sign and the result sign differs. Each overflow bit is ORed into the sticky outOverflow.
  - Hyperbolic repeats: indices 4 and 13 are each executed twice when ≤N. The hyperbolic sequence is i=1..N plus the repeats.
  - Step counts S: circular/linear S=N; hyperbolic S = N + (N≥4) + (N≥13).
  - After step S-1, go to DONE.
- DONE: outValid=1; outputs are stable. On outReady, go to IDLE.
- LUT constants: round(f(2^-i)·2^p_ANGLE_FRAC), produced by an elaboration-time constant function. Index 0 of the atanh table is unused.
- Results carry the CORDIC gain, which is not compensated: K≈1.64676 circular, Kh≈0.82816 hyperbolic.

## Timing

- Reset values: inReady=0 while rstN=0, then 1 in IDLE; outValid=0, outX/outY/outZ=0, outOverflow=0, outError=0, busy=0, state=IDLE.
- Latency: accepted at edge k → outValid high after edge k+S+1. Illegal mode: outValid high after edge k+1.
- Throughput: one operation per S+2 cycles with outReady held high. inReady=0 through RUN and DONE.
- inValid=1 while inReady=0 is ignored; the operation is not queued.
- outValid and all outputs hold until the cycle with outValid && outReady. outReady while outValid=0 has no effect.
- Inputs are sampled only at the accept edge; changes during RUN are ignored.
- rstN asserted mid-RUN or in DONE: immediate return to reset values; the operation in flight is discarded.
- N=1: circular S=1, hyperbolic S=1; no repeats.

## Configuration

- CORDIC_HYPERBOLIC_EN defined: hyperbolic mode (01) is supported, and the atanh LUT and repeat logic are compiled in.
- Not defined: mode 01 is treated as illegal (outError=1, pass-through, latency 1). The atanh LUT and repeat logic are absent.
- Circular and linear modes are identical in both builds.

## Test plan

Defaults: p_WIDTH=16, N=14, p_ANGLE_FRAC=13.

- Circular rotation: x=4975, y=0, z=6434 (π/4) → outX≈outY≈5793 ±4, |outZ|≤4, outValid at k+15.
- Circular vectoring: x=8192, y=8192, z=0 → outZ≈6434 ±4, outX≈19078 ±8, |outY|≤4, outOverflow=0.
- Linear: rotation x=8192, y=0, z=4096 → outY≈4096 ±2. Vectoring x=8192, y=2048, z=0 → outZ≈2048 ±2.
- Hyperbolic (CORDIC_HYPERBOLIC_EN defined): x=9892, y=0, z=4096 → outX≈9238 ±6, outY≈4269 ±6, outValid at k+17. Without the macro: outError=1, outputs equal to the inputs, outValid at k+1.
- Overflow and mode: circular vectoring with x=30000, y=30000 → outOverflow[0]=1 (sticky through DONE). inMode=11 → outError=1.
- Handshake and reset: hold outReady=0 for 10 cycles with outputs stable and inReady=0; inValid pulses during RUN are ignored. Drop rstN mid-RUN → all outputs 0 and busy=0 immediately; a new operation after release completes correctly.
